// File: rtl/cricket_pkg.sv
// Shared geometry, scoring-zone bounds and state encoding for the cricket
// game analyzer pipeline.
package cricket_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  // Scoring-zone x boundaries, left to right
  localparam int ZONE_X0 = 23;
  localparam int ZONE_X1 = 45;
  localparam int ZONE_X2 = 71;
  localparam int ZONE_X3 = 100;
  localparam int ZONE_X4 = 116;
  localparam int ZONE_X5 = 145;
  localparam int ZONE_X6 = 171;

  localparam int OUT_X     = 7;
  localparam int OUT_Y_MIN = 175;
  localparam int OUT_Y_MAX = 230;

  localparam int DEF_TICK_DIV  = 833333;
  localparam int DEF_BOWL_Y0   = 120;
  localparam int DEF_BAT_X     = 16;
  localparam int DEF_HIT_Y_MIN = 184;
  localparam int DEF_TRAVEL    = 8;
  localparam int DEF_MISS_X    = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOWL   = 2'd1,
    HIT    = 2'd2,
    REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/frame_tick.sv
// Frame tick generator: one-cycle pulse every TICK_DIV enabled cycles,
// restartable with a synchronous clear.
module frame_tick #(
  parameter int TICK_DIV = 833333
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ball_trajectory.sv
// Ball flight controller: bowl delivery, swing timing resolution into a shot,
// and a one-cycle strike report of the final ball position.
module ball_trajectory
  import cricket_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int BOWL_Y0   = DEF_BOWL_Y0,
  parameter int BAT_X     = DEF_BAT_X,
  parameter int HIT_Y_MIN = DEF_HIT_Y_MIN,
  parameter int TRAVEL    = DEF_TRAVEL,
  parameter int MISS_X    = DEF_MISS_X
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bowl_req,
  input  logic       swing,
  output logic       throw,
  output logic       strike,
  output logic [8:0] pixelx,
  output logic [7:0] pixely,
  output logic       busy
);

  localparam logic [7:0] WIN_LO    = 8'(HIT_Y_MIN);
  localparam logic [7:0] WIN_HI    = 8'(HIT_Y_MIN + 15);
  localparam logic [7:0] MISS_Y    = 8'(HIT_Y_MIN + 16);
  localparam logic [7:0] TRAV_LAST = 8'(TRAVEL - 1);

  state_t     state;
  logic       bowl_q, swing_q;
  logic       bowl_ev, swing_ev;
  logic       tick, tick_clear, tick_en;
  logic       in_window;
  logic [4:0] step, step_calc;
  logic [7:0] hit_ticks;

  assign bowl_ev    = bowl_req && !bowl_q;
  assign swing_ev   = swing && !swing_q;
  assign tick_clear = (state == IDLE) && bowl_ev;
  assign tick_en    = (state == BOWL) || (state == HIT);
  assign in_window  = (pixely >= WIN_LO) && (pixely <= WIN_HI);
  assign step_calc  = 5'(pixely - WIN_LO) + 5'd1;

  frame_tick #(.TICK_DIV(TICK_DIV)) u_frame_tick (
    .clock  (clock),
    .reset  (reset),
    .clear  (tick_clear),
    .enable (tick_en),
    .tick   (tick)
  );

  // A swing in the window beats a coincident tick, including the miss tick
  // on the last row; busy stays up through the strike cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bowl_q    <= 1'b0;
      swing_q   <= 1'b0;
      throw     <= 1'b0;
      strike    <= 1'b0;
      busy      <= 1'b0;
      pixelx    <= '0;
      pixely    <= '0;
      step      <= '0;
      hit_ticks <= '0;
    end else begin
      bowl_q  <= bowl_req;
      swing_q <= swing;
      throw   <= 1'b0;
      strike  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (bowl_ev) begin
            throw  <= 1'b1;
            busy   <= 1'b1;
            pixelx <= 9'(BAT_X);
            pixely <= 8'(BOWL_Y0);
            state  <= BOWL;
          end
        end
        BOWL: begin
          if (swing_ev && in_window) begin
            step      <= step_calc;
            hit_ticks <= '0;
            state     <= HIT;
          end else if (tick) begin
            if (pixely == WIN_HI) begin
              pixelx <= 9'(MISS_X);
              pixely <= MISS_Y;
              state  <= REPORT;
            end else begin
              pixely <= pixely + 8'd1;
            end
          end
        end
        HIT: begin
          if (tick) begin
            pixelx    <= pixelx + {4'b0, step};
            hit_ticks <= hit_ticks + 8'd1;
            if (hit_ticks == TRAV_LAST) state <= REPORT;
          end
        end
        REPORT: begin
          strike <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_trajectory.sv
// Scoreboard bench for ball_trajectory with a fast frame tick.
module tb_ball_trajectory;

  localparam int TICK_DIV = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       bowlReq = 1'b0;
  logic       swing = 1'b0;
  logic       throw, strike, busy;
  logic [8:0] pixelx;
  logic [7:0] pixely;

  typedef struct {
    int x;
    int y;
  } expT;

  expT expQ[$];
  int  vectorsApplied = 0;
  int  miscompares = 0;

  ball_trajectory #(.TICK_DIV(TICK_DIV)) dut (
    .clock    (clock),
    .reset    (reset),
    .bowl_req (bowlReq),
    .swing    (swing),
    .throw    (throw),
    .strike   (strike),
    .pixelx   (pixelx),
    .pixely   (pixely),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // Single comparison point: every check is counted and mismatches reported.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference landing point for a delivery swung at row swingY (-1 = no swing).
  function automatic expT modelLanding(input int swingY);
    expT e;
    if (swingY >= 184 && swingY <= 199) begin
      e.x = 16 + 8 * (swingY - 184 + 1);
      e.y = swingY;
    end else begin
      e.x = 7;
      e.y = 200;
    end
    return e;
  endfunction

  // mode 0: one-cycle swing on first sight of swingY
  // mode 1: swing held from swingY on, extra bowl press at row 160
  // mode 2: one-cycle swing on second sight of swingY (coincides with a tick)
  task automatic applyStimulus(input string name, input int swingY, input int mode, input int expLatency);
    expT exp, got;
    int  cyc, sightings, extraThrows, busyLow;
    bit  sawStrike, swung, bowled2;
    exp = (mode == 1) ? modelLanding(-1) : modelLanding(swingY);
    expQ.push_back(exp);
    @(negedge clock);
    bowlReq = 1'b1;
    @(posedge clock); #1;
    checkOutput({name, ".throw"}, throw, 1);
    checkOutput({name, ".busy_at_throw"}, busy, 1);
    checkOutput({name, ".start_xy"}, {pixelx, pixely}, {9'd16, 8'd120});
    bowlReq = 1'b0;
    cyc = 0; sightings = 0; extraThrows = 0; busyLow = 0;
    sawStrike = 0; swung = 0; bowled2 = 0;
    while (!sawStrike && cyc < 400) begin
      if (mode != 1) swing = 1'b0;
      bowlReq = 1'b0;
      if (pixely == swingY[7:0] && !swung) begin
        sightings++;
        if ((mode == 0) || (mode == 1) || (mode == 2 && sightings == 2)) begin
          swing = 1'b1;
          swung = 1;
        end
      end
      if (mode == 1 && pixely == 8'd160 && !bowled2) begin
        bowlReq = 1'b1;
        bowled2 = 1;
      end
      @(posedge clock); #1;
      cyc++;
      if (throw) extraThrows++;
      if (!busy) busyLow++;
      if (strike) begin
        sawStrike = 1;
        checkOutput({name, ".throw_with_strike"}, throw, 0);
        if (expQ.size() == 0) begin
          checkOutput({name, ".unexpected_strike"}, 1, 0);
        end else begin
          got = expQ.pop_front();
          checkOutput({name, ".pixelx"}, pixelx, got.x);
          checkOutput({name, ".pixely"}, pixely, got.y);
        end
        if (expLatency > 0) checkOutput({name, ".latency"}, cyc, expLatency);
      end
    end
    swing = 1'b0;
    bowlReq = 1'b0;
    checkOutput({name, ".strike_seen"}, sawStrike, 1);
    checkOutput({name, ".extra_throws"}, extraThrows, 0);
    checkOutput({name, ".busy_during_flight"}, busyLow, 0);
    @(posedge clock); #1;
    checkOutput({name, ".busy_after"}, busy, 0);
    checkOutput({name, ".strike_once"}, strike, 0);
    repeat (3) @(posedge clock);
    #1;
    checkOutput({name, ".idle_hold_xy"}, {pixelx, pixely}, {9'(exp.x), 8'(exp.y)});
  endtask

  initial begin
    int pulses;
    // Reset held while inputs toggle: outputs must stay zero.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      bowlReq = i[0];
      swing = i[1];
      #1;
      checkOutput("reset_hold", {throw, strike, busy, pixelx, pixely}, 0);
    end
    @(negedge clock);
    bowlReq = 1'b0;
    swing = 1'b0;
    reset = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (throw || strike || busy) pulses++;
    end
    checkOutput("post_reset_quiet", pulses, 0);
    checkOutput("post_reset_xy", {pixelx, pixely}, 0);

    applyStimulus("miss", -1, 0, 80 * TICK_DIV + 1);
    applyStimulus("hit184", 184, 0, 0);
    applyStimulus("hit194", 194, 0, 0);
    applyStimulus("held_swing", 150, 1, 80 * TICK_DIV + 1);
    applyStimulus("hit199_tick", 199, 2, 0);
    applyStimulus("hit190_tick", 190, 2, 0);

    // Reset in mid-shot must clear outputs asynchronously and cancel the strike.
    @(negedge clock);
    bowlReq = 1'b1;
    @(posedge clock); #1;
    bowlReq = 1'b0;
    for (int i = 0; i < 400 && pixely != 8'd190; i++) begin
      @(posedge clock); #1;
    end
    swing = 1'b1;
    for (int i = 0; i < 400 && pixelx < 9'd40; i++) begin
      @(posedge clock); #1;
      swing = 1'b0;
    end
    checkOutput("midshot_reached", (pixelx >= 9'd40) ? 1 : 0, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", {throw, strike, busy, pixelx, pixely}, 0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      bowlReq = i[0];
      swing = ~i[0];
      #1;
      if (strike || throw || busy) pulses++;
    end
    @(negedge clock);
    bowlReq = 1'b0;
    swing = 1'b0;
    reset = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (strike || throw || busy) pulses++;
    end
    checkOutput("reset_cancels", pulses, 0);
    applyStimulus("after_reset", 186, 0, 0);

    checkOutput("queue_drained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
